task1_top: RTL and testbench

Top-level FPGA wrapper for the first ARC4 stage: state-array initialisation. After reset it fills a 256×8 on-chip RAM `s` with the identity permutation, s[i] = i for i = 0..255. It then holds idle with a done indication. Later stages (key scheduling, PRGA) reuse the same RAM and init engine.

---
 rtl/arc4_pkg.sv | 20 ++
 rtl/init.sv | 59 +++++
 rtl/s_mem.sv | 25 ++
 rtl/task1_top.sv | 106 ++++++++++
 tb/tb_task1_top.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arc4_pkg.sv
// Shared constants and state types for the ARC4 datapath stages.
// The state array geometry is fixed by the cipher: 256 bytes.
package arc4_pkg;

   localparam int S_DEPTH = 256;
   localparam int S_AW    = 8;
   localparam int S_DW    = 8;

   typedef enum logic {
      INIT_IDLE,
      INIT_WRITE
   } init_state_t;

   typedef enum logic [1:0] {
      SEQ_START,
      SEQ_WAIT,
      SEQ_DONE
   } seq_state_t;

endpackage

// File: rtl/init.sv
// State-array init engine: writes s[i] = i for i = 0..255, one write per cycle.
// en is accepted only while rdy is high; en during a fill is ignored.
module init
   import arc4_pkg::*;
(
   input  logic            clk,
   input  logic            srst,
   input  logic            en,
   output logic            rdy,
   output logic [S_AW-1:0] addr,
   output logic [S_DW-1:0] wrdata,
   output logic            wren
);

   init_state_t   state_reg;
   logic [S_AW:0] i_reg;   // one spare bit so the last address never wraps to 0
   logic          rdy_reg;
   logic          wren_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg <= INIT_IDLE;
         i_reg     <= '0;
         rdy_reg   <= 1'b1;
         wren_reg  <= 1'b0;
      end else begin
         case (state_reg)
            INIT_IDLE: begin
               if (en && rdy_reg) begin
                  i_reg     <= '0;
                  state_reg <= INIT_WRITE;
                  rdy_reg   <= 1'b0;
                  wren_reg  <= 1'b1;
               end
            end
            INIT_WRITE: begin
               if (i_reg == (S_AW + 1)'(S_DEPTH - 1)) begin
                  state_reg <= INIT_IDLE;
                  rdy_reg   <= 1'b1;
                  wren_reg  <= 1'b0;
               end else begin
                  i_reg <= i_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= INIT_IDLE;
               rdy_reg   <= 1'b1;
               wren_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign rdy    = rdy_reg;
   assign wren   = wren_reg;
   assign addr   = i_reg[S_AW-1:0];
   assign wrdata = i_reg[S_DW-1:0];

endmodule

// File: rtl/s_mem.sv
// 256x8 single-port state-array RAM with registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module s_mem
   import arc4_pkg::*;
(
   input  logic            clk,
   input  logic [S_AW-1:0] address,
   input  logic [S_DW-1:0] wrdata,
   input  logic            wren,
   output logic [S_DW-1:0] rddata
);

   logic [S_DW-1:0] mem [S_DEPTH];
   logic [S_DW-1:0] rddata_reg;

   always_ff @(posedge clk) begin
      if (wren) begin
         mem[address] <= wrdata;
      end
      rddata_reg <= mem[address];
   end

   assign rddata = rddata_reg;

endmodule

// File: rtl/task1_top.sv
// ARC4 stage 1 board wrapper: kicks the init engine once after reset and
// lights LEDR[0] when the state array holds the identity permutation.
module task1_top
   import arc4_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [9:0] LEDR
);

   logic            srst;
   logic            init_en;
   logic            init_rdy;
   logic [S_AW-1:0] init_addr;
   logic [S_DW-1:0] init_wrdata;
   logic            init_wren;

   logic [S_AW-1:0] ram_addr;
   logic [S_DW-1:0] ram_wrdata;
   logic            ram_wren;
   logic [S_DW-1:0] unused_rddata;
   logic            unused_inputs;

   seq_state_t seq_state_reg;
   logic       en_reg;
   logic       done_reg;

   assign srst          = ~KEY[3];
   assign unused_inputs = ^{SW, KEY[2:0]};

   // en_reg doubles as a one-cycle guard in SEQ_WAIT: rdy is still high the
   // cycle the pulse is being sampled, so it must not be read as completion.
   always_ff @(posedge CLOCK_50) begin
      if (srst) begin
         seq_state_reg <= SEQ_START;
         en_reg        <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         case (seq_state_reg)
            SEQ_START: begin
               if (init_rdy) begin
                  en_reg        <= 1'b1;
                  seq_state_reg <= SEQ_WAIT;
               end
            end
            SEQ_WAIT: begin
               if (en_reg) begin
                  en_reg <= 1'b0;
               end else if (init_rdy) begin
                  seq_state_reg <= SEQ_DONE;
                  done_reg      <= 1'b1;
               end
            end
            SEQ_DONE: begin
               en_reg <= 1'b0;
            end
            default: begin
               seq_state_reg <= SEQ_START;
               en_reg        <= 1'b0;
               done_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign init_en = en_reg;

   init init_eng (
      .clk    (CLOCK_50),
      .srst   (srst),
      .en     (init_en),
      .rdy    (init_rdy),
      .addr   (init_addr),
      .wrdata (init_wrdata),
      .wren   (init_wren)
   );

   // Only the init engine owns the RAM port in this stage.
   assign ram_addr   = init_addr;
   assign ram_wrdata = init_wrdata;
   assign ram_wren   = init_wren;

   s_mem s (
      .clk     (CLOCK_50),
      .address (ram_addr),
      .wrdata  (ram_wrdata),
      .wren    (ram_wren),
      .rddata  (unused_rddata)
   );

   assign LEDR = {9'b0, done_reg};
   assign HEX0 = 7'b1111111;
   assign HEX1 = 7'b1111111;
   assign HEX2 = 7'b1111111;
   assign HEX3 = 7'b1111111;
   assign HEX4 = 7'b1111111;
   assign HEX5 = 7'b1111111;

endmodule

// File: tb/tb_task1_top.sv
// Self-checking bench for task1_top: fill sequencing, reset behaviour,
// ignored inputs and post-completion stability against a timing/content model.
module tb_task1_top;

   logic       CLOCK_50 = 1'b0;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [9:0] LEDR;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hex_err   = 0;
   int rst_wren  = 0;
   int log_addr [$];
   int log_data [$];
   int log_cyc  [$];
   int exp_mem  [256];
   bit exp_known[256];

   task1_top dut (
      .CLOCK_50 (CLOCK_50),
      .KEY      (KEY),
      .SW       (SW),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5),
      .LEDR     (LEDR)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc = cyc + 1;

   // Passive monitor of the RAM write port and the blank displays.
   always @(negedge CLOCK_50) begin
      if (dut.ram_wren === 1'b1) begin
         log_addr.push_back(int'(dut.ram_addr));
         log_data.push_back(int'(dut.ram_wrdata));
         log_cyc.push_back(cyc);
         if (KEY[3] === 1'b0) rst_wren = rst_wren + 1;
      end
      if ({HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} !== {6{7'h7F}}) hex_err = hex_err + 1;
   end

   task automatic step();
      @(negedge CLOCK_50);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic hold_reset(input int n);
      KEY = 4'b0000;
      SW  = 10'($urandom);
      repeat (n) step();
   endtask

   task automatic release_reset();
      KEY = 4'b1000;
      cyc = -1;
      clear_log();
   endtask

   // Model: a completed fill leaves the identity permutation.
   task automatic model_fill_complete();
      for (int a = 0; a < 256; a++) begin
         exp_mem[a]   = a;
         exp_known[a] = 1'b1;
      end
   endtask

   task automatic test_reset();
      hold_reset(300);
      if (LEDR !== 10'd0) begin
         bad++; $display("FAIL reset_ledr got=%b want=%b", LEDR, 10'd0);
      end
      total++;
      if (dut.init_rdy !== 1'b1) begin
         bad++; $display("FAIL reset_rdy got=%b want=1", dut.init_rdy);
      end
      total++;
      if (rst_wren != 0) begin
         bad++; $display("FAIL reset_wren got=%0d want=0", rst_wren);
      end
      total++;
      $display("test_reset: 300 cycles in reset checked");
   endtask

   task automatic test_fill();
      int n_ok;
      hold_reset(int'($urandom_range(1, 5)));
      release_reset();
      for (int k = 0; k < 275; k++) begin
         step();
         if (cyc == 200) begin
            if (LEDR !== 10'd0) begin
               bad++; $display("FAIL fill_early_done cyc=%0d got=%b want=0", cyc, LEDR);
            end
            total++;
         end
         if (cyc == 257) begin
            if (dut.init_rdy !== 1'b1) begin
               bad++; $display("FAIL fill_rdy cyc=%0d got=%b want=1", cyc, dut.init_rdy);
            end
            total++;
         end
         if (cyc == 259) begin
            if (LEDR !== 10'b0000000001) begin
               bad++; $display("FAIL fill_ledr cyc=%0d got=%b want=0000000001", cyc, LEDR);
            end
            total++;
         end
      end
      model_fill_complete();
      if (log_addr.size() != 256) begin
         bad++; $display("FAIL fill_write_count got=%0d want=256", log_addr.size());
      end
      total++;
      n_ok = 0;
      for (int k = 0; k < log_addr.size() && k < 256; k++) begin
         if (log_addr[k] !== k || log_data[k] !== k || log_cyc[k] !== k + 1) begin
            bad++;
            $display("FAIL fill_write_seq idx=%0d got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                     k, log_addr[k], log_data[k], log_cyc[k], k, k, k + 1);
         end else begin
            n_ok++;
         end
         total++;
      end
      for (int a = 0; a < 256; a++) begin
         if (exp_known[a] && int'(dut.s.mem[a]) !== exp_mem[a]) begin
            bad++; $display("FAIL fill_mem addr=%0d got=%0d want=%0d", a, dut.s.mem[a], exp_mem[a]);
         end
         total++;
      end
      $display("test_fill: %0d writes logged, %0d in order", log_addr.size(), n_ok);
   endtask

   task automatic test_mid_fill_reset();
      int abort_len;
      hold_reset(2);
      release_reset();
      while (cyc < 100) step();
      if (log_addr.size() == 0) begin
         bad++; $display("FAIL midfill_started got=0 writes want>0");
      end
      total++;
      abort_len = int'($urandom_range(1, 4));
      hold_reset(abort_len);
      if (dut.ram_wren !== 1'b0 || LEDR !== 10'd0) begin
         bad++; $display("FAIL midfill_abort got wren=%b ledr=%b want wren=0 ledr=0", dut.ram_wren, LEDR);
      end
      total++;
      release_reset();
      repeat (275) step();
      if (log_addr.size() != 256) begin
         bad++; $display("FAIL midfill_write_count got=%0d want=256", log_addr.size());
      end
      total++;
      for (int k = 0; k < log_addr.size() && k < 256; k++) begin
         if (log_addr[k] !== k || log_cyc[k] !== k + 1) begin
            bad++; $display("FAIL midfill_write_seq idx=%0d got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                            k, log_addr[k], log_cyc[k], k, k + 1);
         end
         total++;
      end
      model_fill_complete();
      for (int a = 0; a < 256; a++) begin
         if (int'(dut.s.mem[a]) !== exp_mem[a]) begin
            bad++; $display("FAIL midfill_mem addr=%0d got=%0d want=%0d", a, dut.s.mem[a], exp_mem[a]);
         end
         total++;
      end
      if (LEDR[0] !== 1'b1) begin
         bad++; $display("FAIL midfill_ledr got=%b want=1", LEDR[0]);
      end
      total++;
      $display("test_mid_fill_reset: abort held %0d cycles, %0d writes after release", abort_len, log_addr.size());
   endtask

   task automatic test_ignored_inputs();
      int hex_before;
      hex_before = hex_err;
      hold_reset(3);
      release_reset();
      for (int k = 0; k < 275; k++) begin
         KEY = {1'b1, 3'($urandom)};
         SW  = 10'($urandom);
         step();
      end
      if (log_addr.size() != 256) begin
         bad++; $display("FAIL ignored_write_count got=%0d want=256", log_addr.size());
      end
      total++;
      for (int k = 0; k < log_addr.size() && k < 256; k++) begin
         if (log_addr[k] !== k || log_data[k] !== k || log_cyc[k] !== k + 1) begin
            bad++; $display("FAIL ignored_write_seq idx=%0d got addr=%0d data=%0d cyc=%0d want %0d/%0d/%0d",
                            k, log_addr[k], log_data[k], log_cyc[k], k, k, k + 1);
         end
         total++;
      end
      if (hex_err != hex_before) begin
         bad++; $display("FAIL ignored_hex got=%0d bad samples want=0", hex_err - hex_before);
      end
      total++;
      if (LEDR !== 10'b0000000001) begin
         bad++; $display("FAIL ignored_ledr got=%b want=0000000001", LEDR);
      end
      total++;
      $display("test_ignored_inputs: %0d writes with random SW/KEY[2:0]", log_addr.size());
   endtask

   task automatic test_done_stable();
      int led_drop;
      led_drop = 0;
      clear_log();
      for (int k = 0; k < 1000; k++) begin
         KEY = {1'b1, 3'($urandom)};
         SW  = 10'($urandom);
         step();
         if (LEDR[0] !== 1'b1) led_drop++;
      end
      if (log_addr.size() != 0) begin
         bad++; $display("FAIL done_extra_writes got=%0d want=0", log_addr.size());
      end
      total++;
      if (led_drop != 0) begin
         bad++; $display("FAIL done_ledr_drop got=%0d cycles want=0", led_drop);
      end
      total++;
      for (int a = 0; a < 256; a++) begin
         if (int'(dut.s.mem[a]) !== exp_mem[a]) begin
            bad++; $display("FAIL done_mem addr=%0d got=%0d want=%0d", a, dut.s.mem[a], exp_mem[a]);
         end
         total++;
      end
      if (hex_err != 0) begin
         bad++; $display("FAIL hex_blank got=%0d bad samples want=0", hex_err);
      end
      total++;
      $display("test_done_stable: 1000 idle cycles, %0d writes", log_addr.size());
   endtask

   // After a completed fill, holding reset must not disturb the array.
   task automatic test_reset_keeps_mem();
      rst_wren = 0;
      hold_reset(int'($urandom_range(20, 60)));
      for (int a = 0; a < 256; a++) begin
         if (int'(dut.s.mem[a]) !== exp_mem[a]) begin
            bad++; $display("FAIL reset_keeps_mem addr=%0d got=%0d want=%0d", a, dut.s.mem[a], exp_mem[a]);
         end
         total++;
      end
      if (rst_wren != 0 || LEDR !== 10'd0 || dut.init_rdy !== 1'b1) begin
         bad++; $display("FAIL reset_after_done got wren_cnt=%0d ledr=%b rdy=%b want 0/0/1",
                         rst_wren, LEDR, dut.init_rdy);
      end
      total++;
      $display("test_reset_keeps_mem: memory retained through reset");
   endtask

   initial begin
      KEY = 4'b0000;
      SW  = 10'd0;
      for (int a = 0; a < 256; a++) begin
         exp_mem[a]   = 0;
         exp_known[a] = 1'b0;
      end
      test_reset();
      test_fill();
      test_reset_keeps_mem();
      test_mid_fill_reset();
      test_ignored_inputs();
      test_done_stable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
